// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Keeps a shift history of accepted bits, compares the newest len_r bits
// against the programmed pattern, and emits a registered one-cycle pulse per
// match together with a saturating match count. Overlapping or
// non-overlapping detection is selected per matching edge.
module seq_detector_prog #(
    parameter int                   PATTERN_W       = 4,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1011,
    parameter int                   DEFAULT_LEN     = 4,
    parameter int                   CNT_W           = 8
) (
    input  logic                             clk_c,
    input  logic                             reset_rn,
    input  logic                             in_i,
    input  logic                             valid_i,
    input  logic                             load_i,
    input  logic [PATTERN_W-1:0]             pattern_i,
    input  logic [$clog2(PATTERN_W+1)-1:0]   len_i,
    input  logic                             overlap_i,
    input  logic                             cnt_clr_i,
    output logic                             q_o,
    output logic [CNT_W-1:0]                 count_o
);

    localparam int              LEN_W   = $clog2(PATTERN_W + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PATTERN_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Fill-level view of the history: nothing, partial, or enough bits to match.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    logic [PATTERN_W-1:0] r_pat;
    logic [LEN_W-1:0]     r_len;
    logic [PATTERN_W-1:0] r_sr;
    logic [LEN_W-1:0]     r_fill;
    state_t               r_state;
    logic                 r_q;
    logic [CNT_W-1:0]     r_count;

    logic [PATTERN_W-1:0] w_sr_shift;
    logic [LEN_W-1:0]     w_fill_inc;
    logic [PATTERN_W-1:0] w_mask;
    logic                 w_eq;
    logic                 w_armed;
    logic                 w_match;
    logic [LEN_W-1:0]     w_len_clamp;
    logic [LEN_W-1:0]     w_len_nxt;
    logic [LEN_W-1:0]     w_fill_nxt;
    state_t               w_state_nxt;

    // Post-shift history, saturating fill increment and masked pattern compare.
    always_comb begin
        w_sr_shift = {r_sr[PATTERN_W-2:0], in_i};
        if (r_fill >= MAX_LEN) begin
            w_fill_inc = MAX_LEN;
        end else begin
            w_fill_inc = r_fill + LEN_ONE;
        end
        w_mask = '0;
        for (int i = 0; i < PATTERN_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_eq = (((w_sr_shift ^ r_pat) & w_mask) == '0);
    end

    // Whether the incoming bit completes enough history for a compare.
    always_comb begin
        w_armed = 1'b0;
        case (r_state)
            ST_EMPTY:   w_armed = (r_len == LEN_ONE);
            ST_FILLING: w_armed = (w_fill_inc >= r_len);
            ST_ARMED:   w_armed = 1'b1;
            default:    w_armed = 1'b0;
        endcase
        w_match = valid_i & ~load_i & w_armed & w_eq;
    end

    // Clamp a newly loaded length into 1..PATTERN_W.
    always_comb begin
        w_len_clamp = len_i;
        if (len_i == '0) begin
            w_len_clamp = LEN_ONE;
        end else if (len_i > MAX_LEN) begin
            w_len_clamp = MAX_LEN;
        end else begin
            w_len_clamp = len_i;
        end
    end

    // Next fill level, length and fill state; load wins, then accepted bits.
    always_comb begin
        w_fill_nxt  = r_fill;
        w_len_nxt   = r_len;
        w_state_nxt = r_state;
        if (load_i) begin
            w_fill_nxt = '0;
            w_len_nxt  = w_len_clamp;
        end else if (valid_i) begin
            if (w_match && !overlap_i) begin
                w_fill_nxt = '0;
            end else begin
                w_fill_nxt = w_fill_inc;
            end
        end else begin
            w_fill_nxt = r_fill;
        end
        if (w_fill_nxt == '0) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_fill_nxt < w_len_nxt) begin
            w_state_nxt = ST_FILLING;
        end else begin
            w_state_nxt = ST_ARMED;
        end
    end

    // Configuration, history and fill-state registers.
    always_ff @(posedge clk_c or negedge reset_rn) begin
        if (!reset_rn) begin
            r_pat   <= DEFAULT_PATTERN;
            r_len   <= LEN_W'(DEFAULT_LEN);
            r_sr    <= '0;
            r_fill  <= '0;
            r_state <= ST_EMPTY;
        end else begin
            if (load_i) begin
                r_pat <= pattern_i;
                r_sr  <= '0;
            end else if (valid_i) begin
                r_sr <= w_sr_shift;
            end
            r_len   <= w_len_nxt;
            r_fill  <= w_fill_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Registered match pulse and saturating match counter.
    always_ff @(posedge clk_c or negedge reset_rn) begin
        if (!reset_rn) begin
            r_q     <= 1'b0;
            r_count <= '0;
        end else begin
            r_q <= w_match;
            if (cnt_clr_i) begin
                r_count <= '0;
            end else if (w_match && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign q_o     = r_q;
    assign count_o = r_count;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog (PATTERN_W=4, CNT_W=2).
// Each step pushes the expected {q_o, count_o} into a scoreboard queue when
// the stimulus is driven; the entry is popped and compared after the edge.
module tb_seq_detector_prog;

    logic       clk_c;
    logic       reset_rn;
    logic       in_i;
    logic       valid_i;
    logic       load_i;
    logic [3:0] pattern_i;
    logic [2:0] len_i;
    logic       overlap_i;
    logic       cnt_clr_i;
    logic       q_o;
    logic [1:0] count_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] sb_q[$];

    seq_detector_prog #(
        .PATTERN_W      (4),
        .DEFAULT_PATTERN(4'b1011),
        .DEFAULT_LEN    (4),
        .CNT_W          (2)
    ) dut (
        .clk_c    (clk_c),
        .reset_rn (reset_rn),
        .in_i     (in_i),
        .valid_i  (valid_i),
        .load_i   (load_i),
        .pattern_i(pattern_i),
        .len_i    (len_i),
        .overlap_i(overlap_i),
        .cnt_clr_i(cnt_clr_i),
        .q_o      (q_o),
        .count_o  (count_o)
    );

    // 10-unit clock
    initial clk_c = 1'b0;
    always #5 clk_c = ~clk_c;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic b, input logic v, input logic ld,
                        input logic [3:0] pat, input logic [2:0] len, input logic clr,
                        input logic eq, input logic [1:0] ec);
        logic [2:0] e;
        in_i      = b;
        valid_i   = v;
        load_i    = ld;
        pattern_i = pat;
        len_i     = len;
        cnt_clr_i = clr;
        sb_q.push_back({eq, ec});
        @(posedge clk_c);
        #1;
        e = sb_q.pop_front();
        cmp({tag, ".q"},   {7'd0, q_o},     {7'd0, e[2]});
        cmp({tag, ".cnt"}, {6'd0, count_o}, {6'd0, e[1:0]});
    endtask

    task automatic vb(input string tag, input logic b, input logic eq, input logic [1:0] ec);
        step(tag, b, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, eq, ec);
    endtask

    task automatic gap(input string tag, input logic b, input logic eq, input logic [1:0] ec);
        step(tag, b, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, eq, ec);
    endtask

    // Load with count clear; a valid 1 is presented and must be discarded.
    task automatic ld(input string tag, input logic [3:0] pat, input logic [2:0] len);
        step(tag, 1'b1, 1'b1, 1'b1, pat, len, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        reset_rn  = 1'b0;
        in_i      = 1'b0;
        valid_i   = 1'b0;
        load_i    = 1'b0;
        pattern_i = 4'd0;
        len_i     = 3'd0;
        overlap_i = 1'b1;
        cnt_clr_i = 1'b0;

        #12;
        cmp("rst.q",   {7'd0, q_o},     8'd0);
        cmp("rst.cnt", {6'd0, count_o}, 8'd0);
        #10;
        reset_rn = 1'b1;

        // Default pattern 1011, len 4
        vb("d1_b1", 1'b1, 1'b0, 2'd0);
        vb("d1_b2", 1'b0, 1'b0, 2'd0);
        vb("d1_b3", 1'b1, 1'b0, 2'd0);
        vb("d1_b4", 1'b1, 1'b1, 2'd1);
        gap("d1_idle", 1'b1, 1'b0, 2'd1);
        step("d1_clr", 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 2'd0);
        vb("d2_b1", 1'b1, 1'b0, 2'd0);
        vb("d2_b2", 1'b1, 1'b0, 2'd0);
        vb("d2_b3", 1'b0, 1'b0, 2'd0);
        vb("d2_b4", 1'b1, 1'b0, 2'd0);
        vb("d2_b5", 1'b1, 1'b1, 2'd1);

        // Pattern 101, len 3, overlapping
        overlap_i = 1'b1;
        ld("ov_ld", 4'b0101, 3'd3);
        vb("ov_b1", 1'b1, 1'b0, 2'd0);
        vb("ov_b2", 1'b0, 1'b0, 2'd0);
        vb("ov_b3", 1'b1, 1'b1, 2'd1);
        vb("ov_b4", 1'b0, 1'b0, 2'd1);
        vb("ov_b5", 1'b1, 1'b1, 2'd2);

        // Same pattern, non-overlapping
        overlap_i = 1'b0;
        ld("no_ld", 4'b0101, 3'd3);
        vb("no_b1", 1'b1, 1'b0, 2'd0);
        vb("no_b2", 1'b0, 1'b0, 2'd0);
        vb("no_b3", 1'b1, 1'b1, 2'd1);
        vb("no_b4", 1'b0, 1'b0, 2'd1);
        vb("no_b5", 1'b1, 1'b0, 2'd1);

        // Valid gaps of 3 idle cycles, idle in_i opposite to the real bit
        overlap_i = 1'b1;
        ld("gp_ld", 4'b1011, 3'd4);
        vb("gp_b1", 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) gap("gp_g1", 1'b0, 1'b0, 2'd0);
        vb("gp_b2", 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) gap("gp_g2", 1'b1, 1'b0, 2'd0);
        vb("gp_b3", 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) gap("gp_g3", 1'b0, 1'b0, 2'd0);
        vb("gp_b4", 1'b1, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) gap("gp_g4", 1'b0, 1'b0, 2'd1);

        // len_i=0 clamps to 1, pattern bit 0 = 1
        overlap_i = 1'b0;
        ld("l0_ld", 4'b0001, 3'd0);
        vb("l0_b1", 1'b1, 1'b1, 2'd1);
        vb("l0_b2", 1'b0, 1'b0, 2'd1);
        vb("l0_b3", 1'b1, 1'b1, 2'd2);
        // Saturation with back-to-back overlapping matches
        overlap_i = 1'b1;
        step("sat_clr", 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 2'd0);
        vb("sat_1", 1'b1, 1'b1, 2'd1);
        vb("sat_2", 1'b1, 1'b1, 2'd2);
        vb("sat_3", 1'b1, 1'b1, 2'd3);
        vb("sat_4", 1'b1, 1'b1, 2'd3);
        vb("sat_5", 1'b1, 1'b1, 2'd3);
        // Clear wins over a match on the same edge
        step("clr_on_match", 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1, 2'd0);

        // len_i=7 clamps to 4
        ld("l7_ld", 4'b1011, 3'd7);
        vb("l7_b1", 1'b1, 1'b0, 2'd0);
        vb("l7_b2", 1'b0, 1'b0, 2'd0);
        vb("l7_b3", 1'b1, 1'b0, 2'd0);
        vb("l7_b4", 1'b1, 1'b1, 2'd1);

        // Load during partial match: bit dropped, history flushed
        ld("pm_ld0", 4'b1011, 3'd4);
        vb("pm_b1", 1'b1, 1'b0, 2'd0);
        vb("pm_b2", 1'b0, 1'b0, 2'd0);
        vb("pm_b3", 1'b1, 1'b0, 2'd0);
        ld("pm_ld1", 4'b1011, 3'd4);
        vb("pm_b4", 1'b0, 1'b0, 2'd0);
        vb("pm_b5", 1'b1, 1'b0, 2'd0);
        vb("pm_b6", 1'b1, 1'b0, 2'd0);

        // Asynchronous reset mid-stream after 3 of 4 bits
        ld("ar_ld", 4'b1011, 3'd4);
        vb("ar_b1", 1'b1, 1'b0, 2'd0);
        vb("ar_b2", 1'b0, 1'b0, 2'd0);
        vb("ar_b3", 1'b1, 1'b0, 2'd0);
        vb("ar_b4", 1'b1, 1'b1, 2'd1);
        vb("ar_b5", 1'b1, 1'b0, 2'd1);
        vb("ar_b6", 1'b0, 1'b0, 2'd1);
        vb("ar_b7", 1'b1, 1'b0, 2'd1);
        #2;
        reset_rn = 1'b0;
        valid_i  = 1'b0;
        #1;
        cmp("ar_rst.q",   {7'd0, q_o},     8'd0);
        cmp("ar_rst.cnt", {6'd0, count_o}, 8'd0);
        @(posedge clk_c);
        #2;
        reset_rn = 1'b1;
        vb("ar_after1", 1'b1, 1'b0, 2'd0);
        vb("ar_after2", 1'b0, 1'b0, 2'd0);
        vb("ar_after3", 1'b1, 1'b0, 2'd0);
        vb("ar_after4", 1'b1, 1'b1, 2'd1);
        gap("end_idle", 1'b0, 1'b0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
